// File: rtl/jelly3_fifo_read_stream.sv
// ---------------------------------------------------------------------------
// jelly3_fifo_read_stream
//
// Purpose:
//   Adapts the read port of the jelly3 synchronous/asynchronous FIFOs
//   (rd_en / rd_empty / rd_data with 1 or 2 cycles of RAM read latency) to a
//   valid/ready stream. Reads in flight are tracked in a shift register, and
//   returned words land in a small circular skid buffer. Reads are only issued
//   when there is guaranteed room (buffered + in flight < BUF_SIZE), so no word
//   is lost or duplicated under arbitrary m_ready backpressure.
//
// Parameters:
//   DATA_BITS : word width
//   DOUT_REG  : must match the FIFO's DOUT_REG; read latency = 1 + DOUT_REG
//   BUF_SIZE  : skid buffer depth (>=1); full rate needs BUF_SIZE >= latency+1
//   CNT_BITS  : width of buf_count
//
// Ports:
//   reset            : asynchronous active-high reset
//   clk              : clock (the FIFO read clock)
//   cke              : clock enable, shared with the FIFO rd_cke
//   s_fifo_rd_en     : read request to the FIFO
//   s_fifo_rd_regcke : FIFO output-register enable
//   s_fifo_rd_data   : FIFO read data
//   s_fifo_rd_empty  : FIFO empty flag
//   m_data/m_valid/m_ready : output stream
//   buf_count        : words currently held in the skid buffer
//
// Optional feature (macro JELLY3_FIFO_READ_STREAM_BYPASS_EN):
//   When defined, a word arriving from the FIFO while the buffer is empty is
//   presented on m_data combinationally in the same cycle (first-word latency
//   drops by one). If it is not taken that cycle it is captured as usual and
//   stays on m_data. When undefined, outputs come only from the buffer.
//
// Note: the whole block must be reset together with the FIFO read side; words
// in flight or buffered at reset are discarded.
// ---------------------------------------------------------------------------
module jelly3_fifo_read_stream #(
   parameter int unsigned DATA_BITS = 8,
   parameter bit          DOUT_REG  = 1'b0,
   parameter int unsigned BUF_SIZE  = 4,
   parameter int unsigned CNT_BITS  = $clog2(BUF_SIZE + 1)
) (
   input  logic                  reset,
   input  logic                  clk,
   input  logic                  cke,

   output logic                  s_fifo_rd_en,
   output logic                  s_fifo_rd_regcke,
   input  logic [DATA_BITS-1:0]  s_fifo_rd_data,
   input  logic                  s_fifo_rd_empty,

   output logic [DATA_BITS-1:0]  m_data,
   output logic                  m_valid,
   input  logic                  m_ready,

   output logic [CNT_BITS-1:0]   buf_count
);

   typedef logic [DATA_BITS-1:0] data_t;

   localparam int LATENCY  = DOUT_REG ? 2 : 1;
   localparam int PTR_BITS = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
   // Wide enough for buf_count + inflight without overflow.
   localparam int SUM_BITS = CNT_BITS + 2;

   // -----------------------------------------------------------------------
   // State
   // -----------------------------------------------------------------------
   logic [LATENCY-1:0]  inflight_reg;
   logic [LATENCY-1:0]  inflight_next;
   logic [PTR_BITS-1:0] wr_ptr_reg;
   logic [PTR_BITS-1:0] wr_ptr_next;
   logic [PTR_BITS-1:0] rd_ptr_reg;
   logic [PTR_BITS-1:0] rd_ptr_next;
   logic [CNT_BITS-1:0] buf_count_reg;
   logic [CNT_BITS-1:0] buf_count_next;
   data_t               buf_mem [BUF_SIZE];

   logic [SUM_BITS-1:0] inflight_cnt;
   logic [SUM_BITS-1:0] credit_used;
   logic                rd_last;
   logic                buf_valid;
   logic                pop;
   logic                capture;
   logic                buf_pop;
   logic                issue;
`ifdef JELLY3_FIFO_READ_STREAM_BYPASS_EN
   logic                bypass;
`endif

   function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
      // Explicit wrap so BUF_SIZE need not be a power of two.
      if (p == PTR_BITS'(BUF_SIZE - 1)) begin
         return '0;
      end
      return p + PTR_BITS'(1);
   endfunction

   // -----------------------------------------------------------------------
   // Inflight shift register: bit 0 takes this cycle's read request, the last
   // bit says the FIFO data port carries a valid word this cycle.
   // -----------------------------------------------------------------------
   assign inflight_next[0] = issue;
   for (genvar gi = 1; gi < LATENCY; gi++) begin : g_shift
      assign inflight_next[gi] = inflight_reg[gi-1];
   end

   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight_cnt = inflight_cnt + SUM_BITS'(inflight_reg[i]);
      end
   end

   // -----------------------------------------------------------------------
   // Output selection, transfer and capture decisions
   // -----------------------------------------------------------------------
   always_comb begin
      rd_last   = inflight_reg[LATENCY-1];
      buf_valid = (buf_count_reg != '0);
`ifdef JELLY3_FIFO_READ_STREAM_BYPASS_EN
      bypass    = rd_last & ~buf_valid;
      m_valid   = buf_valid | bypass;
      m_data    = bypass ? s_fifo_rd_data : buf_mem[rd_ptr_reg];
      pop       = m_valid & m_ready & cke;
      // A bypassed word taken this cycle never touches the buffer.
      capture   = rd_last & ~(bypass & pop);
      buf_pop   = pop & ~bypass;
`else
      m_valid   = buf_valid;
      // Asynchronous head read: the buffer is a tiny skid register file and
      // m_data must follow the head pointer without an extra cycle.
      m_data    = buf_mem[rd_ptr_reg];
      pop       = m_valid & m_ready & cke;
      capture   = rd_last;
      buf_pop   = pop;
`endif
   end

   // Credit: a new read is allowed only if, after this cycle's pop, the words
   // already buffered plus those still in flight leave at least one free slot.
   // The pop term cannot underflow: pop needs a buffered or arriving word.
   always_comb begin
      credit_used = SUM_BITS'(buf_count_reg) + inflight_cnt - SUM_BITS'(pop);
      issue       = ~reset & cke & ~s_fifo_rd_empty
                    & (credit_used < SUM_BITS'(BUF_SIZE));
   end

   assign s_fifo_rd_en     = issue;
   assign s_fifo_rd_regcke = cke & ~reset;
   assign buf_count        = buf_count_reg;

   // -----------------------------------------------------------------------
   // Buffer bookkeeping
   // -----------------------------------------------------------------------
   always_comb begin
      wr_ptr_next    = capture ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
      rd_ptr_next    = buf_pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
      buf_count_next = buf_count_reg;
      case ({capture, buf_pop})
         2'b10:   buf_count_next = buf_count_reg + CNT_BITS'(1);
         2'b01:   buf_count_next = buf_count_reg - CNT_BITS'(1);
         default: buf_count_next = buf_count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_reg  <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         buf_count_reg <= '0;
      end else if (cke) begin
         inflight_reg  <= inflight_next;
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         buf_count_reg <= buf_count_next;
      end
   end

   // Storage carries no reset; contents are only meaningful below buf_count.
   always_ff @(posedge clk) begin
      if (cke && capture) begin
         buf_mem[wr_ptr_reg] <= s_fifo_rd_data;
      end
   end

   // The credit rule must make a capture into a full buffer impossible.
   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(cke && capture && (buf_count_reg == CNT_BITS'(BUF_SIZE))));

endmodule
